sm_accumulator: RTL and testbench
=================================

SM_ACCUMULATOR -- requirements
Module: sm_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, 32, total word width in signed-magnitude (bit WIDTH-1 = sign, WIDTH-2:0 = magnitude).
REQ-002 SHALL have parameter FRAC, 17, fractional bits (informational; arithmetic is format-agnostic).
REQ-003 SHALL have parameter CNT_W, 8, width of the term counter.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  signed-magnitude operand.
REQ-009 SHALL have port in_sub  input  1  1 = subtract operand, 0 = add.
REQ-010 SHALL have port in_last  input  1  final operand of the current sum.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port out_data  output  WIDTH  signed-magnitude sum.
REQ-014 SHALL have port out_sat  output  1  saturation occurred at any step of this sum.
REQ-015 SHALL have port out_count  output  CNT_W  beats accepted in this sum (wraps mod 2^CNT_W).

Function
REQ-016 SHALL be a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 SHALL, in ACCUM, accept a beat when in_valid=1 and update acc <= acc ± in_data in the same edge.
REQ-018 SHALL treat subtraction as addition with the operand sign bit inverted.
REQ-019 SHALL compute each step with WIDTH+1-bit two's-complement internally, then convert back to signed-magnitude.
REQ-020 SHALL saturate each step to magnitude 2^(WIDTH-1)-1 with the true sign, and set the sticky sat flag.
REQ-021 SHALL treat input negative zero (sign=1, magnitude=0) as zero; out_data SHALL never be negative zero.
REQ-022 SHALL, on an accepted beat with in_last=1, go to HOLD; out_valid rises the cycle after that beat (latency 1).
REQ-023 SHALL hold out_data, out_sat, out_count stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on out_valid & out_ready, clear acc, sat and count, and return to ACCUM the next cycle (no beat accepted in that handshake cycle).
REQ-025 SHALL ignore in_data/in_sub/in_last when in_valid=0 or in HOLD.
REQ-026 SHALL increment count on each accepted beat, wrapping at 2^CNT_W without affecting the sum.

Reset
REQ-027 SHALL on rst=1 at a clock edge enter ACCUM, clear acc to 0, sat to 0, count to 0; out_valid=0, out_data=0, out_sat=0, out_count=0, in_ready=1 after that edge.
REQ-028 SHALL discard any partial sum or held result when reset is asserted mid-operation; rst has priority over all handshakes.

Structure
REQ-029 SHALL place WIDTH/FRAC defaults, typedef sm_word_t, and the state enum (ACCUM, HOLD) in shared package sm_pkg.
REQ-030 SHALL implement the combinational saturating signed-magnitude add step in one sub-module, sm_sat_add (inputs a, b; outputs sum, sat).

Verification
REQ-031 SHALL cover: add 0x0006487E then add 0x00056FC2 (last) -> out_data 0x000BB840, out_sat 0, out_count 2.
REQ-032 SHALL cover: add 0x00056FC2 then sub 0x0006487E (last) -> out_data 0x8000D8BC; reversed order -> 0x0000D8BC.
REQ-033 SHALL cover: add 0x7FFFFFFF then add 0x00000001 then sub 0x00000001 (last) -> out_data 0x7FFFFFFE, out_sat 1.
REQ-034 SHALL cover: single beat 0x80000000 (last) -> out_data 0x00000000; add 0x00000005 then sub 0x00000005 -> 0x00000000.
REQ-035 SHALL cover: out_ready low 5 cycles after result -> out_data stable, in_ready 0; release -> in_ready 1 next cycle, new sum starts from 0.
REQ-036 SHALL cover: rst asserted after 3 of 5 beats -> all outputs 0, in_ready 1; next 2-beat sum 0x1 + 0x2 -> 0x00000003, out_count 2.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared definitions for the signed-magnitude accumulator.
//   SM_WIDTH   default word width (bit SM_WIDTH-1 = sign, rest = magnitude)
//   SM_FRAC    default fractional bit count (informational only)
//   sm_word_t  signed-magnitude word of the default width
//   sm_state_e accumulator control states
package sm_pkg;

  localparam int unsigned SM_WIDTH = 32;
  localparam int unsigned SM_FRAC  = 17;

  typedef logic [SM_WIDTH-1:0] sm_word_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } sm_state_e;

endpackage

// File: rtl/sm_sat_add.sv
// Combinational saturating signed-magnitude adder.
//   a, b  signed-magnitude operands (negative zero is treated as zero)
//   sum   signed-magnitude result, clamped to +/-(2^(WIDTH-1)-1), never negative zero
//   sat   high when the true result did not fit and was clamped
module sm_sat_add
  import sm_pkg::*;
#(
  parameter int unsigned WIDTH = SM_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);

  localparam int unsigned MagW = WIDTH - 1;

  logic [WIDTH:0] a_ext, b_ext, a_tc, b_tc, s_tc, mag;
  logic           neg;

  always_comb begin
    a_ext = {2'b00, a[MagW-1:0]};
    b_ext = {2'b00, b[MagW-1:0]};
    // Negating a zero magnitude yields zero, so negative zero folds away here.
    a_tc  = a[WIDTH-1] ? -a_ext : a_ext;
    b_tc  = b[WIDTH-1] ? -b_ext : b_ext;
    s_tc  = a_tc + b_tc;
    neg   = s_tc[WIDTH];
    mag   = neg ? -s_tc : s_tc;
    // Any magnitude bit at or above MagW means the result exceeds the max magnitude.
    sat   = (mag[WIDTH:MagW] != 2'b00);
    if (sat) begin
      sum = {neg, {MagW{1'b1}}};
    end else begin
      // A negative two's-complement value always has a nonzero magnitude.
      sum = {neg, mag[MagW-1:0]};
    end
  end

endmodule

// File: rtl/sm_accumulator.sv
// Streaming signed-magnitude accumulator with saturation.
// Beats are summed while in ACCUM; the beat flagged last moves to HOLD where the
// result is presented until the consumer takes it, then the sum restarts from zero.
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        operand handshake; in_data operand, in_sub subtract,
//                            in_last closes the current sum
//   out_valid/out_ready      result handshake; out_data sum, out_sat sticky
//                            saturation flag, out_count beats accepted (wrapping)
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int unsigned WIDTH = SM_WIDTH,
  parameter int unsigned FRAC  = SM_FRAC,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  // FRAC only labels the fixed-point format; it must still describe a legal split.
  if (FRAC > WIDTH - 1) begin : g_frac_chk
    $error("FRAC exceeds the magnitude width");
  end

  sm_state_e        state_q;
  logic [WIDTH-1:0] acc_q;
  logic             sat_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] step_sum;
  logic             step_sat;

  // Subtraction is addition of the operand with its sign flipped.
  assign operand = {in_data[WIDTH-1] ^ in_sub, in_data[WIDTH-2:0]};

  sm_sat_add #(
    .WIDTH(WIDTH)
  ) u_sat_add (
    .a  (acc_q),
    .b  (operand),
    .sum(step_sum),
    .sat(step_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q <= step_sum;
            sat_q <= sat_q | step_sat;
            cnt_q <= cnt_q + CNT_W'(1);
            if (in_last) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_sat   = sat_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed bench for sm_accumulator; expected values are hand-computed.
module tb_sm_accumulator;

  localparam int unsigned Width = 32;
  localparam int unsigned CntW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_data;
  logic             out_sat;
  logic [CntW-1:0]  out_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sm_accumulator #(
    .WIDTH(Width),
    .FRAC (17),
    .CNT_W(CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_count(out_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [Width-1:0] d, input logic sub, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, ".in_ready"},  64'(in_ready),  64'd1);
    check_eq({tag, ".out_data"},  64'(out_data),  64'd0);
    check_eq({tag, ".out_sat"},   64'(out_sat),   64'd0);
    check_eq({tag, ".out_count"}, 64'(out_count), 64'd0);
  endtask

  // Result must be valid the cycle after the last beat; take it and confirm the clear.
  task automatic expect_result(input string tag, input logic [Width-1:0] d, input logic s,
                               input logic [CntW-1:0] c);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, ".ready"}, 64'(in_ready),  64'd0);
    check_eq({tag, ".data"},  64'(out_data),  64'(d));
    check_eq({tag, ".sat"},   64'(out_sat),   64'(s));
    check_eq({tag, ".count"}, 64'(out_count), 64'(c));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_idle({tag, ".clr"});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    send(32'h0006487E, 1'b0, 1'b0);
    send(32'h00056FC2, 1'b0, 1'b1);
    expect_result("add2", 32'h000BB840, 1'b0, 8'd2);

    send(32'h00056FC2, 1'b0, 1'b0);
    send(32'h0006487E, 1'b1, 1'b1);
    expect_result("subneg", 32'h8000D8BC, 1'b0, 8'd2);

    send(32'h0006487E, 1'b0, 1'b0);
    send(32'h00056FC2, 1'b1, 1'b1);
    expect_result("subpos", 32'h0000D8BC, 1'b0, 8'd2);

    send(32'h7FFFFFFF, 1'b0, 1'b0);
    send(32'h00000001, 1'b0, 1'b0);
    send(32'h00000001, 1'b1, 1'b1);
    expect_result("satpos", 32'h7FFFFFFE, 1'b1, 8'd3);

    send(32'hFFFFFFFF, 1'b0, 1'b0);
    send(32'h80000001, 1'b0, 1'b1);
    expect_result("satneg", 32'hFFFFFFFF, 1'b1, 8'd2);

    send(32'h80000003, 1'b0, 1'b0);
    send(32'h80000004, 1'b0, 1'b1);
    expect_result("negneg", 32'h80000007, 1'b0, 8'd2);

    send(32'h80000000, 1'b0, 1'b1);
    expect_result("negzero", 32'h00000000, 1'b0, 8'd1);

    send(32'h00000005, 1'b0, 1'b0);
    send(32'h00000005, 1'b1, 1'b1);
    expect_result("cancel", 32'h00000000, 1'b0, 8'd2);

    // Idle cycles with garbage on the data lines must not disturb a sum in progress.
    send(32'h00000004, 1'b0, 1'b0);
    in_data = 32'h00000123;
    in_last = 1'b1;
    in_sub  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_data = '0;
    in_last = 1'b0;
    in_sub  = 1'b0;
    check_eq("idle.valid", 64'(out_valid), 64'd0);
    check_eq("idle.data",  64'(out_data),  64'h4);
    send(32'h00000002, 1'b0, 1'b1);
    expect_result("idle", 32'h00000006, 1'b0, 8'd2);

    // Backpressure: result held, offered beats ignored, including in the handshake cycle.
    send(32'h00000010, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h00000055;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold.valid", 64'(out_valid), 64'd1);
      check_eq("hold.ready", 64'(in_ready),  64'd0);
      check_eq("hold.data",  64'(out_data),  64'h10);
      check_eq("hold.count", 64'(out_count), 64'd1);
    end
    in_data   = 32'h00000100;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    check_idle("release");
    send(32'h00000007, 1'b0, 1'b1);
    expect_result("restart", 32'h00000007, 1'b0, 8'd1);

    // Reset mid-sum, with a beat offered in the reset cycle.
    send(32'h7FFFFFFF, 1'b0, 1'b0);
    send(32'h00000001, 1'b0, 1'b0);
    send(32'h00000003, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h00000009;
    in_last  = 1'b1;
    do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    check_idle("rstmid");
    send(32'h00000001, 1'b0, 1'b0);
    send(32'h00000002, 1'b0, 1'b1);
    expect_result("afterrst", 32'h00000003, 1'b0, 8'd2);

    // Reset while a result is held.
    send(32'h00000009, 1'b0, 1'b1);
    check_eq("rsthold.pre", 64'(out_valid), 64'd1);
    do_reset();
    check_idle("rsthold");

    // Counter wraps after 256 beats; the sum is unaffected.
    for (int i = 0; i < 256; i++) begin
      send(32'h00000001, 1'b0, 1'b0);
    end
    send(32'h00000001, 1'b0, 1'b1);
    expect_result("wrap", 32'h00000101, 1'b0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
